// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arb_pkg
//  Description : Shared types and constants for the TX FIFO write-port arbiter
//  Revision    : 1.0  initial release
// ============================================================================
package tx_arb_pkg;

   // Arbiter state encoding (2-bit)
   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_SEND_REG    = 2'd1,
      ST_SEND_ALU_LO = 2'd2,
      ST_SEND_ALU_HI = 2'd3
   } tx_state_t;

   // Requester identifiers, also used as bit positions in request/grant vectors
   localparam int unsigned REQ_REG = 0;
   localparam int unsigned REQ_ALU = 1;
   localparam int unsigned NUM_REQ = 2;

   // Number of FIFO bytes that make up one ALU result
   localparam int unsigned ALU_RATIO = 2;

endpackage : tx_arb_pkg
`default_nettype wire

// File: rtl/tx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rr_pick
//  Description : Combinational 2-way round-robin pick; the pointer names the
//                requester that wins when both request at once.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_rr_pick
   import tx_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               ptr_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   // One-hot grant: a lone request wins outright, a collision goes to the pointer
   always_comb begin
      gnt_o = '0;
      if (req_i[REQ_REG] && (!req_i[REQ_ALU] || (ptr_i == 1'(REQ_REG)))) begin
         gnt_o[REQ_REG] = 1'b1;
      end else if (req_i[REQ_ALU]) begin
         gnt_o[REQ_ALU] = 1'b1;
      end
   end

endmodule : tx_rr_pick
`default_nettype wire

// File: rtl/tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo_arbiter
//  Description : Shares the async FIFO write port between register-file read
//                bytes and 16-bit ALU results (sent as low then high byte).
//                Round-robin req/gnt arbitration, FIFO_FULL back-pressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_fifo_arbiter
   import tx_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ALU_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REG_REQ,
   input  logic [DATA_WIDTH-1:0] REG_DATA,
   output logic                  REG_GNT,
   input  logic                  ALU_REQ,
   input  logic [ALU_WIDTH-1:0]  ALU_DATA,
   output logic                  ALU_GNT,
   input  logic                  ALU_HI_EN,
   input  logic                  FIFO_FULL,
   output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
   output logic                  FIFO_WR_INC,
   output logic                  BUSY
);

   if (ALU_WIDTH != int'(ALU_RATIO) * DATA_WIDTH) begin : g_width_check
      $error("tx_fifo_arbiter: ALU_WIDTH must equal 2*DATA_WIDTH");
   end

   tx_state_t             state_q, state_d;
   logic [ALU_WIDTH-1:0]  hold_q, hold_d;
   logic                  ptr_q, ptr_d;
   logic                  hi_en_q, hi_en_d;
   logic                  reg_gnt_q, reg_gnt_d;
   logic                  alu_gnt_q, alu_gnt_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  wr_inc_q, wr_inc_d;
   logic                  busy_q, busy_d;

   logic [NUM_REQ-1:0]    w_req;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_wr_ok;

   assign w_req[REQ_REG] = REG_REQ;
   assign w_req[REQ_ALU] = ALU_REQ;

   // FULL lags a write by one cycle, so never write in the cycle right after a strobe
   assign w_wr_ok = !FIFO_FULL && !wr_inc_q;

   tx_rr_pick u_pick (
      .req_i (w_req),
      .ptr_i (ptr_q),
      .gnt_o (w_gnt)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: grant from IDLE, advance on each issued write
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_gnt[REQ_REG]) begin
               state_d = ST_SEND_REG;
            end else if (w_gnt[REQ_ALU]) begin
               state_d = ST_SEND_ALU_LO;
            end
         end
         ST_SEND_REG: begin
            if (w_wr_ok) state_d = ST_IDLE;
         end
         ST_SEND_ALU_LO: begin
            if (w_wr_ok) state_d = hi_en_q ? ST_SEND_ALU_HI : ST_IDLE;
         end
         ST_SEND_ALU_HI: begin
            if (w_wr_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values: capture on grant, emit bytes on write issue
   always_comb begin
      hold_d    = hold_q;
      ptr_d     = ptr_q;
      hi_en_d   = hi_en_q;
      reg_gnt_d = 1'b0;
      alu_gnt_d = 1'b0;
      wr_data_d = wr_data_q;
      wr_inc_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_gnt[REQ_REG]) begin
               reg_gnt_d = 1'b1;
               hold_d    = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, REG_DATA};
               ptr_d     = 1'(REQ_ALU);
            end else if (w_gnt[REQ_ALU]) begin
               alu_gnt_d = 1'b1;
               hold_d    = ALU_DATA;
               hi_en_d   = ALU_HI_EN;
               ptr_d     = 1'(REQ_REG);
            end
         end
         ST_SEND_REG, ST_SEND_ALU_LO: begin
            if (w_wr_ok) begin
               wr_inc_d  = 1'b1;
               wr_data_d = hold_q[DATA_WIDTH-1:0];
            end
         end
         ST_SEND_ALU_HI: begin
            if (w_wr_ok) begin
               wr_inc_d  = 1'b1;
               wr_data_d = hold_q[ALU_WIDTH-1:DATA_WIDTH];
            end
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Datapath and registered outputs; reset abandons any pending byte
   always_ff @(posedge CLK) begin
      if (!RST) begin
         hold_q    <= '0;
         ptr_q     <= 1'(REQ_REG);
         hi_en_q   <= 1'b0;
         reg_gnt_q <= 1'b0;
         alu_gnt_q <= 1'b0;
         wr_data_q <= '0;
         wr_inc_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         ptr_q     <= ptr_d;
         hi_en_q   <= hi_en_d;
         reg_gnt_q <= reg_gnt_d;
         alu_gnt_q <= alu_gnt_d;
         wr_data_q <= wr_data_d;
         wr_inc_q  <= wr_inc_d;
         busy_q    <= busy_d;
      end
   end

   assign REG_GNT      = reg_gnt_q;
   assign ALU_GNT      = alu_gnt_q;
   assign FIFO_WR_DATA = wr_data_q;
   assign FIFO_WR_INC  = wr_inc_q;
   assign BUSY         = busy_q;

endmodule : tx_fifo_arbiter
`default_nettype wire

// File: tb/tb_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_fifo_arbiter
//  Description : Self-checking bench for tx_fifo_arbiter: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_fifo_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        REG_REQ = 1'b0;
   logic [7:0]  REG_DATA = '0;
   logic        ALU_REQ = 1'b0;
   logic [15:0] ALU_DATA = '0;
   logic        ALU_HI_EN = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic        REG_GNT, ALU_GNT, FIFO_WR_INC, BUSY;
   logic [7:0]  FIFO_WR_DATA;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   tx_fifo_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REG_REQ      (REG_REQ),
      .REG_DATA     (REG_DATA),
      .REG_GNT      (REG_GNT),
      .ALU_REQ      (ALU_REQ),
      .ALU_DATA     (ALU_DATA),
      .ALU_GNT      (ALU_GNT),
      .ALU_HI_EN    (ALU_HI_EN),
      .FIFO_FULL    (FIFO_FULL),
      .FIFO_WR_DATA (FIFO_WR_DATA),
      .FIFO_WR_INC  (FIFO_WR_INC),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Reference model: a transfer is a queue of bytes still owed to the FIFO
   logic [7:0] m_q[$];
   bit         m_alu_next = 1'b0;   // collision winner: 0 = register, 1 = ALU
   logic       m_rgnt = 1'b0, m_agnt = 1'b0, m_inc = 1'b0, m_busy = 1'b0;
   logic [7:0] m_data = '0;

   always @(posedge CLK) begin
      bit prev_inc;
      bit g_reg;
      bit g_alu;
      if (!RST) begin
         m_q.delete();
         m_alu_next = 1'b0;
         m_rgnt = 1'b0; m_agnt = 1'b0; m_inc = 1'b0; m_busy = 1'b0; m_data = '0;
      end else begin
         prev_inc = m_inc;
         m_rgnt = 1'b0; m_agnt = 1'b0; m_inc = 1'b0;
         if (m_q.size() == 0) begin
            g_reg = REG_REQ && (!ALU_REQ || !m_alu_next);
            g_alu = ALU_REQ && !g_reg;
            if (g_reg) begin
               m_q.push_back(REG_DATA);
               m_rgnt = 1'b1;
               m_alu_next = 1'b1;
            end else if (g_alu) begin
               m_q.push_back(ALU_DATA[7:0]);
               if (ALU_HI_EN) m_q.push_back(ALU_DATA[15:8]);
               m_agnt = 1'b1;
               m_alu_next = 1'b0;
            end
         end else if (!FIFO_FULL && !prev_inc) begin
            m_data = m_q.pop_front();
            m_inc  = 1'b1;
         end
         m_busy = (m_q.size() != 0);
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("m_reg_gnt", 16'(REG_GNT), 16'(m_rgnt));
         chk("m_alu_gnt", 16'(ALU_GNT), 16'(m_agnt));
         chk("m_wr_inc",  16'(FIFO_WR_INC), 16'(m_inc));
         chk("m_wr_data", 16'(FIFO_WR_DATA), 16'(m_data));
         chk("m_busy",    16'(BUSY), 16'(m_busy));
      end
   end

   initial begin
      int         nw;
      int         ng;
      int         rk;
      int         ak;
      logic [7:0] stream[6];
      logic [7:0] exp3[6];
      bit         gorder[4];

      exp3 = '{8'h10, 8'hB0, 8'hA0, 8'h11, 8'hB1, 8'hA1};

      // Reset state
      repeat (2) tick();
      chk("rst_reg_gnt", 16'(REG_GNT), 16'h0);
      chk("rst_alu_gnt", 16'(ALU_GNT), 16'h0);
      chk("rst_wr_inc",  16'(FIFO_WR_INC), 16'h0);
      chk("rst_wr_data", 16'(FIFO_WR_DATA), 16'h0);
      chk("rst_busy",    16'(BUSY), 16'h0);
      RST = 1'b1;
      chk_en = 1'b1;

      // 1: single register byte
      repeat (2) tick();
      REG_REQ = 1'b1; REG_DATA = 8'hA5;
      tick();
      chk("t1_gnt", 16'(REG_GNT), 16'h1);
      chk("t1_busy", 16'(BUSY), 16'h1);
      chk("t1_inc_early", 16'(FIFO_WR_INC), 16'h0);
      REG_REQ = 1'b0;
      tick();
      chk("t1_inc", 16'(FIFO_WR_INC), 16'h1);
      chk("t1_data", 16'(FIFO_WR_DATA), 16'h00A5);
      chk("t1_gnt_off", 16'(REG_GNT), 16'h0);
      tick();
      chk("t1_busy_off", 16'(BUSY), 16'h0);
      chk("t1_inc_off", 16'(FIFO_WR_INC), 16'h0);
      chk("t1_data_hold", 16'(FIFO_WR_DATA), 16'h00A5);

      // 2: ALU result with and without the high byte
      repeat (2) tick();
      ALU_REQ = 1'b1; ALU_DATA = 16'h1234; ALU_HI_EN = 1'b1;
      tick();
      chk("t2_gnt", 16'(ALU_GNT), 16'h1);
      ALU_REQ = 1'b0;
      tick();
      chk("t2_lo_inc", 16'(FIFO_WR_INC), 16'h1);
      chk("t2_lo_data", 16'(FIFO_WR_DATA), 16'h0034);
      chk("t2_lo_busy", 16'(BUSY), 16'h1);
      chk("t2_single_gnt", 16'(ALU_GNT), 16'h0);
      tick();
      chk("t2_gap", 16'(FIFO_WR_INC), 16'h0);
      tick();
      chk("t2_hi_inc", 16'(FIFO_WR_INC), 16'h1);
      chk("t2_hi_data", 16'(FIFO_WR_DATA), 16'h0012);
      chk("t2_hi_busy", 16'(BUSY), 16'h0);
      repeat (2) tick();
      ALU_REQ = 1'b1; ALU_HI_EN = 1'b0;
      tick();
      chk("t2b_gnt", 16'(ALU_GNT), 16'h1);
      ALU_REQ = 1'b0;
      tick();
      chk("t2b_inc", 16'(FIFO_WR_INC), 16'h1);
      chk("t2b_data", 16'(FIFO_WR_DATA), 16'h0034);
      chk("t2b_busy", 16'(BUSY), 16'h0);
      repeat (2) begin
         tick();
         chk("t2b_no_hi", 16'(FIFO_WR_INC), 16'h0);
      end

      // 3: persistent collision after reset alternates REG, ALU, ...
      RST = 1'b0;
      tick();
      RST = 1'b1;
      REG_REQ = 1'b1; REG_DATA = 8'h10;
      ALU_REQ = 1'b1; ALU_DATA = 16'hA0B0; ALU_HI_EN = 1'b1;
      nw = 0; ng = 0; rk = 0; ak = 0;
      for (int cyc = 0; cyc < 60 && nw < 6; cyc++) begin
         tick();
         if (REG_GNT) begin
            if (ng < 4) gorder[ng] = 1'b0;
            ng++; rk++;
            REG_DATA = 8'(8'h10 + rk);
         end
         if (ALU_GNT) begin
            if (ng < 4) gorder[ng] = 1'b1;
            ng++; ak++;
            ALU_DATA = {8'(8'hA0 + ak), 8'(8'hB0 + ak)};
         end
         if (FIFO_WR_INC) begin
            stream[nw] = FIFO_WR_DATA;
            nw++;
         end
      end
      REG_REQ = 1'b0; ALU_REQ = 1'b0;
      chk("t3_write_count", 16'(nw), 16'd6);
      chk("t3_grant_count", 16'(ng >= 4), 16'h1);
      if (nw == 6 && ng >= 4) begin
         for (int i = 0; i < 4; i++) chk("t3_grant_order", 16'(gorder[i]), 16'(i % 2));
         for (int i = 0; i < 6; i++) chk("t3_stream", 16'(stream[i]), 16'(exp3[i]));
      end

      // 4: FIFO full while the high byte is pending
      repeat (4) tick();
      ALU_REQ = 1'b1; ALU_DATA = 16'h5678; ALU_HI_EN = 1'b1;
      tick();
      chk("t4_gnt", 16'(ALU_GNT), 16'h1);
      ALU_REQ = 1'b0;
      tick();
      chk("t4_lo_data", 16'(FIFO_WR_DATA), 16'h0078);
      FIFO_FULL = 1'b1;
      REG_REQ = 1'b1; REG_DATA = 8'h3C;
      repeat (10) begin
         tick();
         chk("t4_full_inc", 16'(FIFO_WR_INC), 16'h0);
         chk("t4_full_gnt", 16'(REG_GNT), 16'h0);
         chk("t4_full_busy", 16'(BUSY), 16'h1);
      end
      FIFO_FULL = 1'b0;
      tick();
      chk("t4_hi_inc", 16'(FIFO_WR_INC), 16'h1);
      chk("t4_hi_data", 16'(FIFO_WR_DATA), 16'h0056);
      chk("t4_reg_wait", 16'(REG_GNT), 16'h0);
      tick();
      chk("t4_reg_gnt", 16'(REG_GNT), 16'h1);
      REG_REQ = 1'b0;
      tick();
      chk("t4_reg_data", 16'(FIFO_WR_DATA), 16'h003C);
      chk("t4_reg_inc", 16'(FIFO_WR_INC), 16'h1);

      // 5: reset while the high byte is pending
      repeat (3) tick();
      ALU_REQ = 1'b1; ALU_DATA = 16'h9ABC; ALU_HI_EN = 1'b1;
      tick();
      ALU_REQ = 1'b0;
      tick();
      chk("t5_lo_data", 16'(FIFO_WR_DATA), 16'h00BC);
      RST = 1'b0;
      tick();
      chk("t5_rst_reg_gnt", 16'(REG_GNT), 16'h0);
      chk("t5_rst_alu_gnt", 16'(ALU_GNT), 16'h0);
      chk("t5_rst_inc", 16'(FIFO_WR_INC), 16'h0);
      chk("t5_rst_data", 16'(FIFO_WR_DATA), 16'h0);
      chk("t5_rst_busy", 16'(BUSY), 16'h0);
      RST = 1'b1;
      REG_REQ = 1'b1; REG_DATA = 8'h77;
      ALU_REQ = 1'b1; ALU_DATA = 16'h4455; ALU_HI_EN = 1'b0;
      tick();
      chk("t5_reg_first", 16'(REG_GNT), 16'h1);
      chk("t5_alu_wait", 16'(ALU_GNT), 16'h0);
      REG_REQ = 1'b0;
      tick();
      chk("t5_reg_data", 16'(FIFO_WR_DATA), 16'h0077);
      tick();
      chk("t5_alu_gnt", 16'(ALU_GNT), 16'h1);
      ALU_REQ = 1'b0;
      tick();
      chk("t5_alu_data", 16'(FIFO_WR_DATA), 16'h0055);
      tick();
      chk("t5_no_stale_hi", 16'(FIFO_WR_INC), 16'h0);

      // 6: REG_REQ held through its grant is a second request
      repeat (3) tick();
      REG_REQ = 1'b1; REG_DATA = 8'h5A;
      tick();
      chk("t6_gnt1", 16'(REG_GNT), 16'h1);
      tick();
      chk("t6_wr1", 16'(FIFO_WR_DATA), 16'h005A);
      chk("t6_inc1", 16'(FIFO_WR_INC), 16'h1);
      tick();
      chk("t6_gnt2", 16'(REG_GNT), 16'h1);
      REG_REQ = 1'b0;
      tick();
      chk("t6_wr2", 16'(FIFO_WR_DATA), 16'h005A);
      chk("t6_inc2", 16'(FIFO_WR_INC), 16'h1);

      // Randomized traffic, back-pressure and occasional reset
      for (int i = 0; i < 3000; i++) begin
         tick();
         RST       = ($urandom_range(0, 199) != 0);
         FIFO_FULL = ($urandom_range(0, 3) == 0);
         if (REG_GNT) REG_REQ = 1'b0;
         else if (!REG_REQ && $urandom_range(0, 2) == 0) begin
            REG_REQ  = 1'b1;
            REG_DATA = 8'($urandom);
         end
         if (ALU_GNT) ALU_REQ = 1'b0;
         else if (!ALU_REQ && $urandom_range(0, 2) == 0) begin
            ALU_REQ   = 1'b1;
            ALU_DATA  = 16'($urandom);
            ALU_HI_EN = 1'($urandom_range(0, 1));
         end
      end
      RST = 1'b1; REG_REQ = 1'b0; ALU_REQ = 1'b0; FIFO_FULL = 1'b0;
      repeat (5) tick();
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_tx_fifo_arbiter
`default_nettype wire
